uart_receiver: RTL and testbench
================================

UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 The block SHALL have parameter CLOCK_FREQ, default 50_000_000, meaning the clk frequency in Hz.
REQ-002 The block SHALL have parameter BAUD_RATE, default 115_200, meaning the serial bit rate in bits/s.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock (cpu_clk_g domain); all logic is on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port serial_in, input, 1 bit: asynchronous UART line (FPGA_SERIAL_RX), idle high.
REQ-006 The block SHALL have port data_out, output, 8 bits: received byte.
REQ-007 The block SHALL have port data_out_valid, output, 1 bit: data_out holds an unconsumed byte.
REQ-008 The block SHALL have port data_out_ready, input, 1 bit: the consumer (MIPS150 MMIO) accepts a byte this cycle.
REQ-009 The block SHALL have port framing_error, output, 1 bit: one-cycle pulse when a bad stop bit is seen.
REQ-010 The block SHALL have port overrun, output, 1 bit: one-cycle pulse when a completed byte is dropped.
REQ-011 The block SHALL have port busy, output, 1 bit: high in every FSM state other than IDLE.

Function
REQ-012 serial_in SHALL pass through a 2-flop synchronizer (flops reset to 1); all FSM decisions use the synchronized value.
REQ-013 Timing SHALL use a bit-time count EDGE = CLOCK_FREQ/BAUD_RATE (integer division) and a sample point MID = EDGE/2, with a counter wide enough for EDGE-1.
REQ-014 The FSM SHALL have four states, IDLE, START, DATA and STOP, with the transitions given in REQ-015 to REQ-018.
REQ-015 In IDLE, synchronized line = 0 SHALL move the FSM to START and clear the counter.
REQ-016 In START, at counter = MID a sample of 0 SHALL move the FSM to DATA; a sample of 1 is a glitch and SHALL return the FSM to IDLE with no output and no error.
REQ-017 In DATA, the FSM SHALL sample every EDGE cycles after the start mid-point, shift 8 bits LSB first, and after bit 7 move to STOP.
REQ-018 In STOP, the FSM SHALL sample one EDGE after bit 7: a 1 commits the byte, a 0 pulses framing_error for 1 cycle and discards the byte; both cases return to IDLE in the same cycle.
REQ-019 On commit, data_out_valid SHALL be 1 and data_out SHALL be valid on the cycle after the stop sample.
REQ-020 A transfer SHALL occur on a cycle with data_out_valid=1 and data_out_ready=1; data_out_valid SHALL stay high and data_out SHALL stay stable until the transfer; data_out_ready while data_out_valid=0 SHALL have no effect.
REQ-021 A commit while storage is full SHALL drop the new byte, pulse overrun for 1 cycle and leave the stored data untouched.
REQ-022 A commit in the same cycle as a transfer from full storage SHALL be accepted with no overrun.
REQ-023 Reception SHALL continue independently of data_out_ready; back-to-back frames with a single stop bit SHALL be received without loss while storage has room.

Reset
REQ-024 While rst_n=0, FSM=IDLE, counters=0, synchronizer=1, storage=empty, data_out=8'h00, and data_out_valid, framing_error, overrun and busy all SHALL be 0.
REQ-025 Reset asserted mid-frame SHALL abort the frame, and the partial byte SHALL never appear.
REQ-026 After rst_n deasserts, the block SHALL wait in IDLE for a falling edge; a line already low at deassertion SHALL be treated as a start bit.

Configuration
REQ-027 With macro UART_RECEIVER_FIFO_EN defined, storage SHALL be a 4-entry FIFO: in-order delivery, overrun only on a commit to 4 stored bytes, data_out showing the head entry.
REQ-028 Without UART_RECEIVER_FIFO_EN, storage SHALL be a single holding register, so full means data_out_valid=1.

Verification
REQ-029 Send 0xA5 at 115200 baud with data_out_ready=0 -> data_out=8'hA5, data_out_valid=1 within 10*434+4 cycles of the start edge; hold 100 cycles, then assert ready for 1 cycle -> valid=0 on the next cycle.
REQ-030 Drive serial_in low for 100 cycles, then high -> FSM returns to IDLE, busy falls, data_out_valid and framing_error stay 0.
REQ-031 Send 0x3C with stop bit=0 -> framing_error pulses exactly 1 cycle and data_out_valid stays 0; a following 0x55 frame is received correctly.
REQ-032 Without FIFO, send 0x11 then 0x22 with ready=0 -> overrun pulses once and data_out stays 8'h11; with FIFO, send 0x01..0x05 -> overrun on 0x05 only, and reads return 0x01..0x04 in order.
REQ-033 Assert rst_n=0 during bit 3 of 0xFF, release, then send 0x80 -> only 8'h80 is delivered.
REQ-034 With FIFO full, pop and commit in the same cycle -> no overrun, and the new byte is delivered last.

Source files
------------

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receiver with a valid/ready byte output; define UART_RECEIVER_FIFO_EN for 4-deep storage.
// Latency: 2-cycle input synchronizer; the byte is on data_out the cycle after the stop-bit mid-sample.
// Backpressure: reception never stalls; a byte completed while storage is full is dropped and pulses overrun.
module uart_receiver #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    input  logic       data_out_ready,
    output logic       framing_error,
    output logic       overrun,
    output logic       busy
);
    localparam int EDGE = CLOCK_FREQ / BAUD_RATE;
    localparam int MID  = EDGE / 2;
    localparam int CW   = (EDGE > 2) ? $clog2(EDGE) : 1;
    localparam logic [CW-1:0] EDGE_M1 = CW'(EDGE - 1);
    localparam logic [CW-1:0] MID_C   = CW'(MID);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          sync1_q, sync2_q;
    logic          ferr_q, ferr_d;
    logic          ovr_q, ovr_d;
    logic          commit;
    logic          pop;
    logic          rx;

    assign rx            = sync2_q;
    assign busy          = (state_q != IDLE);
    assign framing_error = ferr_q;
    assign overrun       = ovr_q;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= serial_in;
            sync2_q <= sync1_q;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Bit timing counter, shift register and pulse flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    // Next-state: start bit checked at mid-bit, then one sample per bit time from there.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        commit  = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == MID_C) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    // A high line at mid-start is a glitch: drop back silently.
                    state_d = rx ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (cnt_q == EDGE_M1) begin
                    cnt_d   = '0;
                    shift_d = {rx, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (cnt_q == EDGE_M1) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (rx) commit = 1'b1;
                    else    ferr_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef UART_RECEIVER_FIFO_EN
    logic [7:0] mem_q [4];
    logic [7:0] mem_d [4];
    logic [1:0] wr_q, wr_d, rd_q, rd_d;
    logic [2:0] fcnt_q, fcnt_d;
    logic       push;

    assign data_out       = mem_q[rd_q];
    assign data_out_valid = (fcnt_q != 3'd0);

    // FIFO storage and pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) mem_q[i] <= '0;
            wr_q   <= '0;
            rd_q   <= '0;
            fcnt_q <= '0;
        end else begin
            mem_q  <= mem_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            fcnt_q <= fcnt_d;
        end
    end

    // A pop in the commit cycle frees the slot the new byte needs.
    always_comb begin
        pop    = data_out_valid & data_out_ready;
        push   = commit & ((fcnt_q != 3'd4) | pop);
        ovr_d  = commit & ~push;
        mem_d  = mem_q;
        if (push) mem_d[wr_q] = shift_q;
        wr_d   = wr_q + {1'b0, push};
        rd_d   = rd_q + {1'b0, pop};
        fcnt_d = fcnt_q + {2'b00, push} - {2'b00, pop};
    end
`else
    logic [7:0] hold_dat_q, hold_dat_d;
    logic       hold_vld_q, hold_vld_d;

    assign data_out       = hold_dat_q;
    assign data_out_valid = hold_vld_q;

    // Single holding register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_dat_q <= '0;
            hold_vld_q <= 1'b0;
        end else begin
            hold_dat_q <= hold_dat_d;
            hold_vld_q <= hold_vld_d;
        end
    end

    // Load on commit when empty or being drained this cycle; otherwise drop and flag.
    always_comb begin
        pop        = hold_vld_q & data_out_ready;
        hold_vld_d = hold_vld_q & ~pop;
        hold_dat_d = hold_dat_q;
        ovr_d      = 1'b0;
        if (commit) begin
            if (!hold_vld_q || pop) begin
                hold_vld_d = 1'b1;
                hold_dat_d = shift_q;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed frames against uart_receiver at 50 MHz / 115200 baud.
// Latency: frames take 10 bit times; checks sample #1 after the rising edge.
// Backpressure: data_out_ready driven by the bench, including a pop in the commit cycle.
module tb_uart_receiver;
    localparam int EDGE = 50_000_000 / 115_200;   // 434

    logic       clk = 1'b0;
    logic       rst_n;
    logic       serial_in;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       data_out_ready;
    logic       framing_error;
    logic       overrun;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    int ferr_cnt = 0;
    int ovr_cnt  = 0;
    int base_f;
    int base_o;

    uart_receiver #(.CLOCK_FREQ(50_000_000), .BAUD_RATE(115_200)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .serial_in      (serial_in),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .framing_error  (framing_error),
        .overrun        (overrun),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // Count high cycles of each error pulse.
    always @(negedge clk) begin
        if (framing_error) ferr_cnt <= ferr_cnt + 1;
        if (overrun)       ovr_cnt  <= ovr_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one 8N1 frame; pop_at >= 0 raises ready for exactly that cycle index.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int pop_at);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        for (int c = 0; c < 10 * EDGE; c++) begin
            serial_in = fr[c / EDGE];
            if (pop_at >= 0) data_out_ready = (c == pop_at);
            @(posedge clk);
            #1;
        end
        serial_in      = 1'b1;
        data_out_ready = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        chk({tag, "_vld"}, {31'd0, data_out_valid}, 32'd1);
        chk({tag, "_dat"}, {24'd0, data_out}, {24'd0, exp});
        data_out_ready = 1'b1;
        @(posedge clk);
        #1;
        data_out_ready = 1'b0;
    endtask

    initial begin
        rst_n          = 1'b0;
        serial_in      = 1'b1;
        data_out_ready = 1'b0;
        idle(5);
        chk("rst_dat",  {24'd0, data_out}, 32'h0);
        chk("rst_vld",  {31'd0, data_out_valid}, 32'd0);
        chk("rst_ferr", {31'd0, framing_error}, 32'd0);
        chk("rst_ovr",  {31'd0, overrun}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        idle(10);

        // Basic byte with backpressure, then a single-cycle pop.
        send_frame(8'hA5, 1'b1, -1);
        chk("a5_vld", {31'd0, data_out_valid}, 32'd1);
        chk("a5_dat", {24'd0, data_out}, 32'hA5);
        idle(100);
        chk("a5_hold_vld", {31'd0, data_out_valid}, 32'd1);
        chk("a5_hold_dat", {24'd0, data_out}, 32'hA5);
        data_out_ready = 1'b1;
        @(posedge clk);
        #1;
        data_out_ready = 1'b0;
        chk("a5_pop_vld", {31'd0, data_out_valid}, 32'd0);
        idle(20);

        // Short low glitch on the line.
        base_f    = ferr_cnt;
        serial_in = 1'b0;
        idle(50);
        chk("glitch_busy_hi", {31'd0, busy}, 32'd1);
        idle(50);
        serial_in = 1'b1;
        idle(300);
        chk("glitch_busy_lo", {31'd0, busy}, 32'd0);
        chk("glitch_vld", {31'd0, data_out_valid}, 32'd0);
        chk("glitch_ferr", ferr_cnt - base_f, 32'd0);

        // Bad stop bit, then a good frame.
        base_f = ferr_cnt;
        send_frame(8'h3C, 1'b0, -1);
        idle(600);
        chk("ferr_pulse", ferr_cnt - base_f, 32'd1);
        chk("ferr_vld", {31'd0, data_out_valid}, 32'd0);
        send_frame(8'h55, 1'b1, -1);
        idle(50);
        pop_check("after_ferr", 8'h55);
        chk("after_ferr_empty", {31'd0, data_out_valid}, 32'd0);

        base_o = ovr_cnt;
`ifdef UART_RECEIVER_FIFO_EN
        for (int k = 1; k <= 4; k++) begin
            send_frame(8'(k), 1'b1, -1);
            idle(20);
        end
        chk("fifo_no_ovr", ovr_cnt - base_o, 32'd0);
        send_frame(8'h05, 1'b1, -1);
        idle(20);
        chk("fifo_ovr", ovr_cnt - base_o, 32'd1);
        chk("fifo_head", {24'd0, data_out}, 32'h01);
        // Pop the head in the exact cycle the stop bit commits 0x06.
        base_o = ovr_cnt;
        send_frame(8'h06, 1'b1, 4126);
        idle(20);
        chk("fifo_popcommit_ovr", ovr_cnt - base_o, 32'd0);
        pop_check("fifo_rd2", 8'h02);
        pop_check("fifo_rd3", 8'h03);
        pop_check("fifo_rd4", 8'h04);
        pop_check("fifo_rd6", 8'h06);
        chk("fifo_empty", {31'd0, data_out_valid}, 32'd0);
`else
        send_frame(8'h11, 1'b1, -1);
        idle(20);
        send_frame(8'h22, 1'b1, -1);
        idle(20);
        chk("ovr_pulse", ovr_cnt - base_o, 32'd1);
        chk("ovr_dat", {24'd0, data_out}, 32'h11);
        chk("ovr_vld", {31'd0, data_out_valid}, 32'd1);
        // Pop 0x11 in the exact cycle the stop bit commits 0x33.
        base_o = ovr_cnt;
        send_frame(8'h33, 1'b1, 4126);
        idle(20);
        chk("popcommit_ovr", ovr_cnt - base_o, 32'd0);
        pop_check("popcommit", 8'h33);
        chk("popcommit_empty", {31'd0, data_out_valid}, 32'd0);
`endif
        idle(20);

        // Reset in the middle of bit 3 of 0xFF.
        serial_in = 1'b0;
        idle(EDGE);
        serial_in = 1'b1;
        idle(3 * EDGE + 200);
        chk("mid_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        idle(5);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_vld", {31'd0, data_out_valid}, 32'd0);
        rst_n = 1'b1;
        idle(50);
        send_frame(8'h80, 1'b1, -1);
        idle(20);
        pop_check("after_rst", 8'h80);
        chk("after_rst_empty", {31'd0, data_out_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
